// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor
// Bridges the data cache's single-line physical-memory port to a 4-beat, 64-bit burst memory.
// Each 256-bit line read or write from the cache becomes one burst. The cache sees a one-cycle
// pmem_resp pulse when the burst completes.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   pmem_read/write     line request from cache, held until pmem_resp
//   pmem_address        line address, [4:0] ignored
//   pmem_wdata256       line to write
//   pmem_rdata256       last assembled read line (register)
//   pmem_resp           one-cycle completion pulse
//   mem_read/write      burst request to memory
//   mem_address         latched line address, [4:0] = 0
//   mem_wdata64         current write beat
//   mem_rdata64         read beat, valid with mem_resp
//   mem_resp            one beat transferred per high cycle
module cacheline_adaptor (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [31:0]  pmem_address,
  input  logic [255:0] pmem_wdata256,
  output logic [255:0] pmem_rdata256,
  output logic         pmem_resp,
  output logic         mem_read,
  output logic         mem_write,
  output logic [31:0]  mem_address,
  output logic [63:0]  mem_wdata64,
  input  logic [63:0]  mem_rdata64,
  input  logic         mem_resp
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  state_e         state_q, state_d;
  logic [1:0]     beat_q, beat_d;
  logic [31:0]    addr_q, addr_d;
  logic [255:0]   wline_q, wline_d;
  logic [255:0]   rline_q, rline_d;

  // Offset bits select a byte within the line and never reach memory.
  logic unused_addr_bits;
  assign unused_addr_bits = ^pmem_address[4:0];

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    addr_d  = addr_q;
    wline_d = wline_q;
    rline_d = rline_q;
    unique case (state_q)
      StIdle: begin
        // Write wins when both requests are present.
        if (pmem_write) begin
          addr_d  = {pmem_address[31:5], 5'b0};
          wline_d = pmem_wdata256;
          beat_d  = 2'd0;
          state_d = StWrite;
        end else if (pmem_read) begin
          addr_d  = {pmem_address[31:5], 5'b0};
          beat_d  = 2'd0;
          state_d = StRead;
        end
      end
      StRead: begin
        if (mem_resp) begin
          rline_d[{beat_q, 6'b0} +: 64] = mem_rdata64;
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'd3) state_d = StDone;
        end
      end
      StWrite: begin
        if (mem_resp) begin
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'd3) state_d = StDone;
        end
      end
      // Return to idle unconditionally; the still-high request is only sampled next edge.
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      beat_q  <= 2'd0;
      addr_q  <= '0;
      wline_q <= '0;
      rline_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      addr_q  <= addr_d;
      wline_q <= wline_d;
      rline_q <= rline_d;
    end
  end

  // Outputs come from registers or state decode only; no path from mem_resp.
  assign pmem_resp     = (state_q == StDone);
  assign mem_read      = (state_q == StRead);
  assign mem_write     = (state_q == StWrite);
  assign mem_address   = addr_q;
  assign mem_wdata64   = wline_q[{beat_q, 6'b0} +: 64];
  assign pmem_rdata256 = rline_q;

endmodule

// File: doc/cacheline_adaptor.md
# cacheline_adaptor

Responder for the data cache's physical-memory port. Accepts one 256-bit line read or write from the cache controller (`pmem_read`/`pmem_write`/`pmem_resp` handshake) and executes it as a 4-beat, 64-bit burst on the external burst memory. Sits between the cache controller and main memory. The cache always sees a single-line transaction with a one-cycle `pmem_resp` pulse.

## Interface
- `BEATS` = 4: beats per line. Fixed; line width = 64 × BEATS = 256.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pmem_read`  in  1  cache line read request; held high until `pmem_resp`.
- `pmem_write`  in  1  cache line write request; held high until `pmem_resp`.
- `pmem_address`  in  32  line address; bits [4:0] ignored.
- `pmem_wdata256`  in  256  line to write; stable while `pmem_write` is high.
- `pmem_rdata256`  out  256  assembled read line; valid when `pmem_resp` is high after a read.
- `pmem_resp`  out  1  one-cycle completion pulse.
- `mem_read`  out  1  burst read request to memory.
- `mem_write`  out  1  burst write request to memory.
- `mem_address`  out  32  latched line address with [4:0] = 0.
- `mem_wdata64`  out  64  current write beat.
- `mem_rdata64`  in  64  read beat; valid when `mem_resp` is high.
- `mem_resp`  in  1  beat transfer strobe, one beat per high cycle.

## Operation
- States: IDLE, READ, WRITE, DONE. A 2-bit beat counter `beat` runs 0..3.
- IDLE:
  - If `pmem_write` is high: latch the address with [4:0] cleared, latch `pmem_wdata256`, set `beat`=0, go to WRITE.
  - Otherwise, if `pmem_read` is high: latch the address, set `beat`=0, go to READ.
  - If both are high, write wins.
  - `mem_resp` is ignored in IDLE.
- READ:
  - `mem_read` is high throughout.
  - On each cycle with `mem_resp`=1, store `mem_rdata64` into line bits [64·beat+63 : 64·beat] and increment `beat`.
  - On the beat-3 transfer, go to DONE.
- WRITE:
  - `mem_write` is high throughout.
  - `mem_wdata64` = latched line [64·beat+63 : 64·beat].
  - On each cycle with `mem_resp`=1, increment `beat`. On the beat-3 transfer, go to DONE.
- DONE:
  - `pmem_resp`=1 for exactly one cycle, then go to IDLE unconditionally.
  - The request from the cache is still high during this cycle. It must not retrigger, because IDLE samples only on the following edge.
- Beats need not be consecutive. Cycles with `mem_resp`=0 stall the counter and hold all outputs.
- Beat counter arithmetic is modulo 4. After the beat-3 transfer it reads 0.
- `pmem_rdata256` is a register. It holds its last assembled value until overwritten by the next read and does not change on writes.
- Changes to `pmem_address` or `pmem_wdata256` after IDLE latches them have no effect on the transaction in flight.

## Timing
- Reset (async, `rst_n`=0):
  - state = IDLE, `beat`=0.
  - `pmem_resp`, `mem_read` and `mem_write` = 0.
  - `mem_address`, `mem_wdata64` and `pmem_rdata256` = 0.
- Reset mid-burst aborts the transaction. No `pmem_resp` is issued. After `rst_n` rises, the first rising edge samples requests in IDLE.
- All outputs are registered or decoded from state only. There is no combinational path from `mem_resp` to `pmem_resp`.
- Read latency: request first high in cycle 0 → `mem_read` high from cycle 1. If `mem_resp` is high in cycles 1–4, `pmem_resp` and valid `pmem_rdata256` appear in cycle 5.
  - General case: `pmem_resp` arrives one cycle after the 4th `mem_resp` cycle.
- Write latency: identical, with `mem_write` in place of `mem_read`.
- `mem_read` and `mem_write` are never high together. Both are low in IDLE and DONE.
- Back-to-back transactions: a write-back followed by a line fill has one IDLE cycle between them.
  - DONE at cycle n → IDLE at n+1 → new request sampled → burst from n+2.

## Test plan
- Read, no stalls:
  - Stimulus: `pmem_address`=0x0000_1234; memory returns beats 0x...00, 0x...11, 0x...22, 0x...33 in cycles 1–4.
  - Required: `mem_address`=0x0000_1220; `pmem_resp` only in cycle 5; `pmem_rdata256` = {beat3, beat2, beat1, beat0}.
- Write with stalls:
  - Stimulus: `pmem_wdata256` = {64'hD, 64'hC, 64'hB, 64'hA}; `mem_resp` pattern 1,0,0,1,1,0,1.
  - Required: `mem_wdata64` = A, B, B, B, C, D, D; `pmem_resp` exactly one cycle after the final strobe.
- Write-back then fill:
  - Stimulus: `pmem_write` held until `pmem_resp`, then `pmem_read` next cycle.
  - Required: the read is not started during the DONE cycle; `mem_read` rises two cycles after `pmem_resp`; `pmem_rdata256` is unchanged by the write.
- Simultaneous requests:
  - Stimulus: `pmem_read`=`pmem_write`=1 in IDLE.
  - Required: a write burst is performed; `mem_read` stays 0.
- Reset mid-read:
  - Stimulus: `rst_n` low after 2 beats.
  - Required: all outputs 0 immediately; no `pmem_resp`. A subsequent full read returns correct data with `beat` starting at 0.
- Spurious `mem_resp` in IDLE:
  - Required: no state change, no `pmem_resp`, and `pmem_rdata256` unchanged.
